// File: rtl/shift_reg_unit_if.sv
// Bus between the control unit and the sequential shift register:
// command (func, n, data_in) toward the shifter, result and handshake back.
interface shift_reg_unit_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
);
    logic [2:0]       func;
    logic [WIDTH-1:0] data_in;
    logic [AMT_W-1:0] n;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             done;

    modport master (
        output func, data_in, n,
        input  data_out, busy, done
    );

    modport slave (
        input  func, data_in, n,
        output data_out, busy, done
    );
endinterface

// File: rtl/shift_reg_unit.sv
// Sequential 32-bit shift register. Shifts one bit position per clock.
// A busy/done handshake lets the control FSM wait for the result.
// The result is taken from data_out by the register-file write-data mux.
module shift_reg_unit #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    shift_reg_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] FN_NOP  = 3'b000;
    localparam logic [2:0] FN_LOAD = 3'b001;
    localparam logic [2:0] FN_SLL  = 3'b010;
    localparam logic [2:0] FN_SRL  = 3'b011;
    localparam logic [2:0] FN_SRA  = 3'b100;
    localparam logic [2:0] FN_ROR  = 3'b101;
    localparam logic [2:0] FN_ROL  = 3'b110;

    state_t           state_q;
    logic [WIDTH-1:0] shiftReg_q;
    logic [AMT_W-1:0] count_q;
    logic [2:0]       op_q;
    logic             busy_q;
    logic             done_q;

    logic [2:0]       stepOp;
    logic [WIDTH-1:0] step_d;

    // One 1-bit step of the active operation applied to the current register value.
    // In IDLE the step uses the incoming func because the accept edge already shifts once.
    always_comb begin
        stepOp = (state_q == IDLE) ? bus.func : op_q;
        step_d = shiftReg_q;
        case (stepOp)
            FN_SLL:  step_d = {shiftReg_q[WIDTH-2:0], 1'b0};
            FN_SRL:  step_d = {1'b0, shiftReg_q[WIDTH-1:1]};
            FN_SRA:  step_d = {shiftReg_q[WIDTH-1], shiftReg_q[WIDTH-1:1]};
            FN_ROR:  step_d = {shiftReg_q[0], shiftReg_q[WIDTH-1:1]};
            FN_ROL:  step_d = {shiftReg_q[WIDTH-2:0], shiftReg_q[WIDTH-1]};
            default: step_d = shiftReg_q;
        endcase
    end

    // Control FSM, data register and handshake flags. busy and done are registered
    // together with the state so that they always match it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            count_q    <= '0;
            op_q       <= FN_NOP;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    case (bus.func)
                        FN_LOAD: begin
                            shiftReg_q <= bus.data_in;
                            state_q    <= DONE;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b1;
                        end
                        FN_SLL, FN_SRL, FN_SRA, FN_ROR, FN_ROL: begin
                            op_q   <= bus.func;
                            busy_q <= 1'b1;
                            if (bus.n == '0) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                shiftReg_q <= step_d;
                                count_q    <= bus.n - AMT_W'(1);
                                if (bus.n == AMT_W'(1)) begin
                                    state_q <= DONE;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q <= SHIFT;
                                    done_q  <= 1'b0;
                                end
                            end
                        end
                        default: begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b0;
                        end
                    endcase
                end
                SHIFT: begin
                    shiftReg_q <= step_d;
                    count_q    <= count_q - AMT_W'(1);
                    if (count_q == AMT_W'(1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out = shiftReg_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_shift_reg_unit.sv
// Self-checking bench for shift_reg_unit. Expected results are pushed to a
// scoreboard queue when a command is driven and popped when done pulses.
module tb_shift_reg_unit;

    localparam int WIDTH = 32;
    localparam int AMT_W = 5;

    typedef struct {
        string       tag;
        logic [31:0] value;
        int          doneCycle;
    } expect_t;

    logic clk;
    logic reset;
    int   cycleCnt;
    int   checkCount;
    int   failCount;
    logic [31:0] modelQ;
    expect_t     sbQueue[$];

    shift_reg_unit_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    shift_reg_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to check done latency.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Single checking routine; every comparison goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, actual, expected, cycleCnt);
        end
    endtask

    // Reference result of a whole shift by amt using plain SV operators.
    function automatic logic [31:0] modelShift(input logic [2:0] f, input logic [31:0] v, input int amt);
        logic signed [31:0] sv;
        sv = v;
        case (f)
            3'b010: return v << amt;
            3'b011: return v >> amt;
            3'b100: return sv >>> amt;
            3'b101: return (amt == 0) ? v : ((v >> amt) | (v << (32 - amt)));
            3'b110: return (amt == 0) ? v : ((v << amt) | (v >> (32 - amt)));
            default: return v;
        endcase
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest pending result.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sbQueue.size() == 0) begin
                checkOutput("spurious_done", 32'd1, 32'd0);
            end else begin
                expect_t e;
                e = sbQueue.pop_front();
                checkOutput(e.tag, bus.data_out, e.value);
                checkOutput({e.tag, "_latency"}, cycleCnt, e.doneCycle);
                checkOutput({e.tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
            end
        end
    end

    // Drive one command at a negedge while idle, push its expectation, then wait
    // (bounded) for done. With disturb set, func/data_in are changed mid-command.
    task automatic applyStimulus(input string tag, input logic [2:0] f, input logic [31:0] d,
                                 input int amt, input bit disturb);
        expect_t e;
        bit      seen;
        int      k;
        @(negedge clk);
        bus.func    = f;
        bus.data_in = d;
        bus.n       = AMT_W'(amt);
        k = cycleCnt + 1;
        if (f == 3'b000 || f == 3'b111) begin
            @(negedge clk);
            bus.func = 3'b000;
            checkOutput({tag, "_nop_busy"}, {31'd0, bus.busy}, 32'd0);
            checkOutput({tag, "_nop_data"}, bus.data_out, modelQ);
            return;
        end
        if (f == 3'b001) begin
            modelQ = d;
            e.doneCycle = k;
        end else begin
            modelQ = modelShift(f, modelQ, amt);
            e.doneCycle = (amt == 0) ? k : k + amt - 1;
        end
        e.tag   = tag;
        e.value = modelQ;
        sbQueue.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!disturb) bus.func = 3'b000;
            else if (i == 3) begin
                bus.func    = 3'b001;
                bus.data_in = 32'h12345678;
                bus.n       = AMT_W'(2);
            end
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        bus.func = 3'b000;
        if (!seen) checkOutput({tag, "_done_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        checkOutput({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
        checkOutput({tag, "_idle_data"}, bus.data_out, modelQ);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        checkCount  = 0;
        failCount   = 0;
        cycleCnt    = 0;
        modelQ      = '0;
        reset       = 1'b1;
        bus.func    = 3'b000;
        bus.data_in = '0;
        bus.n       = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_data", bus.data_out, 32'h0);
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("idle_data", bus.data_out, 32'h0);
            checkOutput("idle_busy", {31'd0, bus.busy}, 32'd0);
        end

        applyStimulus("load_f",   3'b001, 32'h0000000F, 0, 1'b0);
        applyStimulus("sll_4",    3'b010, 32'h0,        4, 1'b0);
        checkOutput("sll_4_const", modelQ, 32'h000000F0);

        applyStimulus("load_msb", 3'b001, 32'h80000000, 0, 1'b0);
        applyStimulus("sra_31",   3'b100, 32'h0,        31, 1'b0);
        applyStimulus("load_msb", 3'b001, 32'h80000000, 0, 1'b0);
        applyStimulus("srl_31",   3'b011, 32'h0,        31, 1'b0);

        applyStimulus("load_ends", 3'b001, 32'h80000001, 0, 1'b0);
        applyStimulus("ror_1",     3'b101, 32'h0,        1, 1'b0);
        applyStimulus("rol_2",     3'b110, 32'h0,        2, 1'b0);
        applyStimulus("sll_0",     3'b010, 32'hFFFFFFFF, 0, 1'b0);
        applyStimulus("reserved",  3'b111, 32'hDEADBEEF, 3, 1'b0);

        applyStimulus("load_pat",  3'b001, 32'h12345678, 0, 1'b0);
        applyStimulus("ror_31",    3'b101, 32'h0,        31, 1'b0);

        applyStimulus("load_ff",   3'b001, 32'hFF000000, 0, 1'b0);
        applyStimulus("srl_8_dist", 3'b011, 32'h0,       8, 1'b1);

        // Reset during SLL by 10 after five steps: no done, register cleared.
        @(negedge clk);
        bus.func = 3'b010;
        bus.n    = AMT_W'(10);
        @(negedge clk);
        bus.func = 3'b000;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        modelQ = '0;
        checkOutput("midreset_data", bus.data_out, 32'h0);
        checkOutput("midreset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("midreset_done", {31'd0, bus.done}, 32'd0);
        repeat (12) @(negedge clk);
        checkOutput("midreset_quiet", bus.data_out, 32'h0);

        applyStimulus("load_a5", 3'b001, 32'hA5A5A5A5, 0, 1'b0);
        applyStimulus("sra_4",   3'b100, 32'h0,        4, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [2:0]  f;
            logic [31:0] d;
            int          amt;
            f   = 3'($urandom_range(1, 6));
            d   = $urandom;
            amt = $urandom_range(0, 31);
            if (f != 3'b001) applyStimulus("rnd_load", 3'b001, d, 0, 1'b0);
            applyStimulus("rnd_op", f, d, amt, 1'b0);
        end

        checkOutput("scoreboard_empty", 32'(sbQueue.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
